// File: rtl/seg_scan_display_if.sv
// Bus between the timer (BCD digit source) and the multiplexed display scanner.
interface seg_scan_display_if;
  logic [23:0] digit_in;
  logic [5:0]  dp_in;
  logic [5:0]  blink_en;
  logic        lz_blank;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_start;

  // Timer side: supplies digits and display attributes, may observe the scan.
  modport master (
    output digit_in, dp_in, blink_en, lz_blank,
    input  seg, sel, frame_start
  );

  // Display side: consumes digits, drives the segment/select pins.
  modport slave (
    input  digit_in, dp_in, blink_en, lz_blank,
    output seg, sel, frame_start
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 6-digit 7-segment scanner with per-frame snapshot, leading-zero
// blanking, per-digit blink, decimal points and ghost blanking at digit switch.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 83,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          SEL_ACT_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_display_if.slave bus
);

  localparam int unsigned NUM_DIG = 6;
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned FRM_W   = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [5:0][3:0]       digit_q, digit_d;
  logic [5:0]            dp_q, dp_d;
  logic [5:0]            blink_q, blink_d;
  logic                  lz_q, lz_d;
  logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [FRM_W-1:0]      frame_cnt_inc;
  logic                  blink_phase_q, blink_phase_d;
  logic [7:0]            seg_q, seg_d;
  logic [5:0]            sel_q, sel_d;
  logic                  frame_start_q, frame_start_d;

  logic                  snap;
  logic [NUM_DIG-1:0]    lz_dark;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;
  logic [7:0]            lit;

  // Active-high gfedcba pattern; non-BCD codes show a bare '-' as an error marker.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  // Slot timing, frame snapshot and blink phase bookkeeping.
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    digit_d       = digit_q;
    dp_d          = dp_q;
    blink_d       = blink_q;
    lz_d          = lz_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_cnt_inc = frame_cnt_q + FRM_W'(1);
    snap          = (cnt_q == '0) && (idx_q == '0);

    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (snap) begin
      digit_d = bus.digit_in;
      dp_d    = bus.dp_in;
      blink_d = bus.blink_en;
      lz_d    = bus.lz_blank;
      if (frame_cnt_inc == FRM_W'(BLINK_FRAMES)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_inc;
      end
    end
  end

  // Pixel path: uses the post-snapshot view so a fresh snapshot shows in its own slot.
  always_comb begin
    seg_d         = '0;
    sel_d         = '0;
    lz_dark       = '0;
    zero_run      = lz_d;
    cur_digit     = '0;
    cur_dp        = 1'b0;
    cur_blink     = 1'b0;
    cur_lz        = 1'b0;
    frame_start_d = snap;

    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      zero_run   = zero_run && (digit_d[i] == 4'd0);
      lz_dark[i] = zero_run;
    end

    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = digit_d[i];
        cur_dp    = dp_d[i];
        cur_blink = blink_d[i];
        cur_lz    = lz_dark[i];
      end
    end

    lit = {cur_dp, cur_lz ? 7'h00 : seg_decode(cur_digit)};
    if (blink_phase_d && cur_blink) begin
      lit = '0;
    end

    if (cnt_q >= CNT_W'(BLANK_CYC)) begin
      seg_d = lit;
      for (int i = 0; i < NUM_DIG; i++) begin
        sel_d[i] = (idx_q == IDX_W'(i));
      end
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      digit_q       <= '0;
      dp_q          <= '0;
      blink_q       <= '0;
      lz_q          <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= '0;
      sel_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      dp_q          <= dp_d;
      blink_q       <= blink_d;
      lz_q          <= lz_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Pin polarity applied last; everything upstream is active-high.
  assign bus.seg         = seg_q ^ {8{SEG_ACT_LOW}};
  assign bus.sel         = sel_q ^ {6{SEL_ACT_LOW}};
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display against a frame/slot arithmetic model.
module tb_seg_scan_display;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYC    = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME_CYC    = SCAN_DIV * 6;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic clk;
  logic rst;

  seg_scan_display_if bus_if ();

  seg_scan_display #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .BLINK_FRAMES(BLINK_FRAMES),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned failures;
  int unsigned k;
  int unsigned cur_k;

  logic [23:0] cur_digit, snap_digit;
  logic [5:0]  cur_dp, snap_dp;
  logic [5:0]  cur_blink, snap_blink;
  logic        cur_lz, snap_lz;
  logic [14:0] exp_out;

  // Expected {seg, sel, frame_start} for output cycle kk after reset release.
  function automatic logic [14:0] model_out(input int unsigned kk);
    int unsigned slot  = (kk / SCAN_DIV) % 6;
    int unsigned pos   = kk % SCAN_DIV;
    int unsigned frame = kk / FRAME_CYC;
    logic        fs    = (kk % FRAME_CYC) == 0;
    logic [3:0]  dv;
    logic        phase;
    logic        lz_dark;
    logic [7:0]  on;
    logic [5:0]  sl;
    if (pos < BLANK_CYC) return {8'hFF, 6'h3F, fs};
    dv      = 4'((snap_digit >> (4 * slot)) & 24'hF);
    phase   = (((frame + 1) / BLINK_FRAMES) % 2) == 1;
    lz_dark = snap_lz && (slot != 0) && ((snap_digit >> (4 * slot)) == 24'd0);
    on      = {snap_dp[slot], SEG_TBL[dv]};
    if (lz_dark) on[6:0] = 7'h00;
    if (phase && snap_blink[slot]) on = 8'h00;
    sl = 6'(1 << slot);
    return {~on, ~sl, fs};
  endfunction

  task automatic set_in(input logic [23:0] d, input logic [5:0] dp,
                        input logic [5:0] bl, input logic lz);
    cur_digit       = d;
    cur_dp          = dp;
    cur_blink       = bl;
    cur_lz          = lz;
    bus_if.digit_in = d;
    bus_if.dp_in    = dp;
    bus_if.blink_en = bl;
    bus_if.lz_blank = lz;
  endtask

  // One clock: record the frame snapshot at the scan start, then compute expectation.
  task automatic advance();
    @(posedge clk);
    if (k % FRAME_CYC == 0) begin
      snap_digit = cur_digit;
      snap_dp    = cur_dp;
      snap_blink = cur_blink;
      snap_lz    = cur_lz;
    end
    cur_k = k;
    k++;
    @(negedge clk);
    exp_out = model_out(cur_k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(24'h0, 6'h0, 6'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== {8'hFF, 6'h3F, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {bus_if.seg, bus_if.sel, bus_if.frame_start}, {8'hFF, 6'h3F, 1'b0});
    end
    checks++;
    repeat (3) @(negedge clk);
    if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== {8'hFF, 6'h3F, 1'b0}) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", {bus_if.seg, bus_if.sel, bus_if.frame_start}, {8'hFF, 6'h3F, 1'b0});
    end
    checks++;
    rst = 1'b1;
    k   = 0;
  endtask

  task automatic test_basic();
    set_in(24'h123456, 6'h0, 6'h0, 1'b0);
    for (int j = 0; j < 2 * FRAME_CYC; j++) begin
      advance();
      if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
        failures++;
        $display("FAIL basic_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
      end
      checks++;
      if (cur_k % FRAME_CYC == 2) begin
        if ({bus_if.seg, bus_if.sel} !== {8'h82, 6'h3E}) begin
          failures++;
          $display("FAIL basic_digit0 got seg=%h sel=%h exp seg=82 sel=3e", bus_if.seg, bus_if.sel);
        end
        checks++;
      end
    end
  endtask

  task automatic test_lz();
    set_in(24'h000105, 6'h0, 6'h0, 1'b1);
    for (int j = 0; j < 2 * FRAME_CYC; j++) begin
      if (j == FRAME_CYC) set_in(24'h000000, 6'h0, 6'h0, 1'b1);
      advance();
      if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
        failures++;
        $display("FAIL lz_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
      end
      checks++;
      if (j == 18 || j == 42 || j == FRAME_CYC + 2 || j == FRAME_CYC + 10) begin
        logic [7:0] want;
        want = (j == 18) ? 8'hF9 : (j == FRAME_CYC + 2) ? 8'hC0 : 8'hFF;
        if (bus_if.seg !== want) begin
          failures++;
          $display("FAIL lz_spot j=%0d got seg=%h exp seg=%h", j, bus_if.seg, want);
        end
        checks++;
      end
    end
  endtask

  task automatic test_snapshot();
    set_in(24'h000001, 6'h0, 6'h0, 1'b0);
    for (int j = 0; j < 2 * FRAME_CYC; j++) begin
      if (j == 3 * SCAN_DIV) set_in(24'h000009, 6'h0, 6'h0, 1'b0);
      advance();
      if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
        failures++;
        $display("FAIL snap_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
      end
      checks++;
      if (j == FRAME_CYC + 2) begin
        if (bus_if.seg !== 8'h90) begin
          failures++;
          $display("FAIL snap_new_frame got seg=%h exp seg=90", bus_if.seg);
        end
        checks++;
      end
    end
  endtask

  task automatic test_blink();
    set_in(24'h123456, 6'h0, 6'b000011, 1'b0);
    for (int j = 0; j < 5 * FRAME_CYC; j++) begin
      advance();
      if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
        failures++;
        $display("FAIL blink_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
      end
      checks++;
      if (cur_k % FRAME_CYC == 18 && bus_if.seg !== 8'h99) begin
        failures++;
        $display("FAIL blink_digit2_lit got seg=%h exp seg=99", bus_if.seg);
      end
      if (cur_k % FRAME_CYC == 18) checks++;
    end
  endtask

  task automatic test_err_dp();
    set_in(24'h12345A, 6'h01, 6'h0, 1'b0);
    for (int j = 0; j < FRAME_CYC; j++) begin
      advance();
      if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
        failures++;
        $display("FAIL err_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
      end
      checks++;
      if (j == 2) begin
        if (bus_if.seg !== 8'h3F) begin
          failures++;
          $display("FAIL err_dash_dp got seg=%h exp seg=3f", bus_if.seg);
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int unsigned chg;
      chg = $urandom_range(1, FRAME_CYC - 1);
      for (int j = 0; j < FRAME_CYC; j++) begin
        if (j == 0 || j == chg) begin
          logic [23:0] d;
          for (int n = 0; n < 6; n++) begin
            d[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
          end
          if ($urandom_range(0, 1) == 1) d[23:12] = 12'h000;
          set_in(d, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end
        advance();
        if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
          failures++;
          $display("FAIL rand_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    set_in(24'h123456, 6'h0, 6'h0, 1'b0);
    for (int j = 0; j < FRAME_CYC; j++) begin
      advance();
      if (cur_k % FRAME_CYC == 3 * SCAN_DIV + 4) break;
    end
    #1 rst = 1'b0;
    #1;
    if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== {8'hFF, 6'h3F, 1'b0}) begin
      failures++;
      $display("FAIL midreset_async got=%h exp=%h", {bus_if.seg, bus_if.sel, bus_if.frame_start}, {8'hFF, 6'h3F, 1'b0});
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
    for (int j = 0; j < FRAME_CYC + SCAN_DIV; j++) begin
      advance();
      if ({bus_if.seg, bus_if.sel, bus_if.frame_start} !== exp_out) begin
        failures++;
        $display("FAIL midreset_model k=%0d got=%h exp=%h", cur_k, {bus_if.seg, bus_if.sel, bus_if.frame_start}, exp_out);
      end
      checks++;
      if (j == 0 && {bus_if.sel, bus_if.frame_start} !== {6'h3F, 1'b1}) begin
        failures++;
        $display("FAIL midreset_restart got sel=%h fs=%b exp sel=3f fs=1", bus_if.sel, bus_if.frame_start);
      end
      if (j == 0) checks++;
      if (j == 2 && {bus_if.seg, bus_if.sel} !== {8'h82, 6'h3E}) begin
        failures++;
        $display("FAIL midreset_digit0 got seg=%h sel=%h exp seg=82 sel=3e", bus_if.seg, bus_if.sel);
      end
      if (j == 2) checks++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    cur_k    = 0;
    test_reset();
    test_basic();
    test_lz();
    test_snapshot();
    test_blink();
    test_err_dp();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
